// File: rtl/dma_pkg.sv
// ============================================================================
// Module      : dma_pkg
// Description : Shared constants, field extractors and legality check for the
//               DMA descriptor sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam logic [7:0] MEM_TOP  = 8'd191;
    localparam logic [7:0] IO1_BASE = 8'd192;
    localparam logic [7:0] IO1_TOP  = 8'd223;
    localparam logic [7:0] IO2_BASE = 8'd224;
    localparam logic [7:0] IO2_TOP  = 8'd255;

    localparam logic [1:0] OP_FROM_IO = 2'b00;
    localparam logic [1:0] OP_FROM_MEM = 2'b01;
    localparam logic [1:0] TYPE_IO    = 2'b01;
    localparam logic [1:0] TYPE_MEM   = 2'b10;

    localparam logic [25:0] NOP_INSTR = {2'b11, 2'b00, 22'b0};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [1:0] instr_op(input logic [25:0] i);
        return i[25:24];
    endfunction

    function automatic logic [1:0] instr_type(input logic [25:0] i);
        return i[23:22];
    endfunction

    function automatic logic [7:0] instr_src(input logic [25:0] i);
        return i[21:14];
    endfunction

    function automatic logic [7:0] instr_dst(input logic [25:0] i);
        return i[13:6];
    endfunction

    function automatic logic [5:0] instr_count(input logic [25:0] i);
        return i[5:0];
    endfunction

    function automatic logic instr_legal(input logic [25:0] i);
        logic [1:0] op;
        logic [1:0] ty;
        logic [7:0] s;
        logic [7:0] d;
        op = instr_op(i);
        ty = instr_type(i);
        s  = instr_src(i);
        d  = instr_dst(i);
        if (op == OP_FROM_MEM && ty == TYPE_IO)
            return (d > MEM_TOP);
        else if (op == OP_FROM_IO && ty == TYPE_IO)
            return (s > MEM_TOP);
        else if (op == OP_FROM_MEM && ty == TYPE_MEM)
            return (s <= MEM_TOP) && (d <= MEM_TOP);
        else
            return 1'b0;
    endfunction

    // Memory addresses step and wrap at the top of memory; I/O ports are fixed.
    function automatic logic [7:0] addr_next(input logic [7:0] a);
        if (a > MEM_TOP)
            return a;
        else if (a == MEM_TOP)
            return 8'd0;
        else
            return a + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_ip_pointer.sv
// ============================================================================
// Module      : dma_ip_pointer
// Description : Interrupt deposit write pointer with wrap and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_ip_pointer #(
    parameter logic [7:0] IP_BASE = 8'd128,
    parameter logic [7:0] IP_TOP  = 8'd191
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       grant,
    input  logic       io_ack1,
    input  logic       io_ack2,
    output logic [7:0] firstempty,
    output logic       ip_overflow
);

    logic [7:0] ptr_q;
    logic [7:0] ptr_d;
    logic       ovf_q;
    logic       ovf_d;

    always_comb begin
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        if (grant && (io_ack1 || io_ack2)) begin
            if (ptr_q == IP_TOP) begin
                ptr_d = IP_BASE;
                ovf_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= IP_BASE;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
        end
    end

    assign firstempty  = ptr_q;
    assign ip_overflow = ovf_q;

endmodule

`default_nettype wire

// File: rtl/dma_descriptor_sequencer.sv
// ============================================================================
// Module      : dma_descriptor_sequencer
// Description : Accepts one DMA instruction, requests the bus and streams
//               per-transfer addresses to the DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_descriptor_sequencer
    import dma_pkg::*;
#(
    parameter logic [7:0] IP_BASE = 8'd128,
    parameter logic [7:0] IP_TOP  = 8'd191
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        grant,
    input  logic        D_IOAck1,
    input  logic        D_IOAck2,
    output logic        bus_request,
    output logic [25:0] DMA_instruction,
    output logic [7:0]  next_source,
    output logic [7:0]  next_destination,
    output logic [7:0]  firstempty,
    output logic [5:0]  remaining,
    output logic        done,
    output logic        err,
    output logic        ip_overflow
);

    logic [1:0]  state_q, state_d;
    logic [25:0] instr_q, instr_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  dst_q, dst_d;
    logic [5:0]  rem_q, rem_d;
    logic        err_q, err_d;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_in;
                    src_d   = instr_src(instr_in);
                    dst_d   = instr_dst(instr_in);
                    rem_d   = instr_count(instr_in);
                    if (!instr_legal(instr_in)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (instr_count(instr_in) == 6'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (grant)
                    state_d = ST_XFER;
            end
            ST_XFER: begin
                // A granted edge issues the transfer currently on the address outputs.
                if (grant) begin
                    src_d = addr_next(src_q);
                    dst_d = addr_next(dst_q);
                    if (rem_q != 6'd0)
                        rem_d = rem_q - 6'd1;
                    if (rem_q <= 6'd1)
                        state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= NOP_INSTR;
            src_q   <= 8'd0;
            dst_q   <= 8'd0;
            rem_q   <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign instr_ready      = (state_q == ST_IDLE);
    assign bus_request      = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign DMA_instruction  = (state_q == ST_XFER) ? instr_q : NOP_INSTR;
    assign next_source      = src_q;
    assign next_destination = dst_q;
    assign remaining        = rem_q;
    assign done             = (state_q == ST_DONE);
    assign err              = err_q;

    dma_ip_pointer #(
        .IP_BASE (IP_BASE),
        .IP_TOP  (IP_TOP)
    ) u_ip_pointer (
        .clock       (clock),
        .reset       (reset),
        .grant       (grant),
        .io_ack1     (D_IOAck1),
        .io_ack2     (D_IOAck2),
        .firstempty  (firstempty),
        .ip_overflow (ip_overflow)
    );

endmodule

`default_nettype wire

// File: tb/tb_dma_descriptor_sequencer.sv
// ============================================================================
// Module      : tb_dma_descriptor_sequencer
// Description : Directed self-checking bench for dma_descriptor_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_descriptor_sequencer;

    localparam logic [25:0] NOP = {2'b11, 2'b00, 22'b0};

    logic        clock;
    logic        reset;
    logic [25:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        grant;
    logic        D_IOAck1;
    logic        D_IOAck2;
    logic        bus_request;
    logic [25:0] DMA_instruction;
    logic [7:0]  next_source;
    logic [7:0]  next_destination;
    logic [7:0]  firstempty;
    logic [5:0]  remaining;
    logic        done;
    logic        err;
    logic        ip_overflow;

    int total;
    int bad;

    dma_descriptor_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .instr_in         (instr_in),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .grant            (grant),
        .D_IOAck1         (D_IOAck1),
        .D_IOAck2         (D_IOAck2),
        .bus_request      (bus_request),
        .DMA_instruction  (DMA_instruction),
        .next_source      (next_source),
        .next_destination (next_destination),
        .firstempty       (firstempty),
        .remaining        (remaining),
        .done             (done),
        .err              (err),
        .ip_overflow      (ip_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [25:0] mk(input logic [1:0] op, input logic [1:0] ty,
                                       input logic [7:0] s, input logic [7:0] d,
                                       input logic [5:0] c);
        return {op, ty, s, d, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        instr_in = 26'd0;
        instr_valid = 1'b0;
        grant = 1'b0;
        D_IOAck1 = 1'b0;
        D_IOAck2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_busreq", 32'(bus_request), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ovf", 32'(ip_overflow), 32'd0);
        check("rst_rem", 32'(remaining), 32'd0);
        check("rst_src", 32'(next_source), 32'd0);
        check("rst_dst", 32'(next_destination), 32'd0);
        check("rst_fe", 32'(firstempty), 32'd128);
        check("rst_instr", 32'(DMA_instruction), 32'(NOP));

        // Memory to IO1, grant held
        instr_in = mk(2'b01, 2'b01, 8'd10, 8'd200, 6'd3);
        instr_valid = 1'b1;
        grant = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("t1_req_bus", 32'(bus_request), 32'd1);
        check("t1_req_ready", 32'(instr_ready), 32'd0);
        check("t1_req_instr", 32'(DMA_instruction), 32'(NOP));
        check("t1_req_rem", 32'(remaining), 32'd3);
        tick();
        check("t1_x_instr", 32'(DMA_instruction), 32'(mk(2'b01, 2'b01, 8'd10, 8'd200, 6'd3)));
        check("t1_src0", 32'(next_source), 32'd10);
        tick();
        check("t1_src1", 32'(next_source), 32'd11);
        check("t1_rem2", 32'(remaining), 32'd2);
        tick();
        check("t1_src2", 32'(next_source), 32'd12);
        check("t1_dst", 32'(next_destination), 32'd200);
        check("t1_done_early", 32'(done), 32'd0);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_rem0", 32'(remaining), 32'd0);
        check("t1_done_bus", 32'(bus_request), 32'd0);
        check("t1_done_ready", 32'(instr_ready), 32'd0);
        check("t1_done_instr", 32'(DMA_instruction), 32'(NOP));
        tick();
        check("t1_idle_ready", 32'(instr_ready), 32'd1);
        check("t1_idle_done", 32'(done), 32'd0);

        // Memory to memory across the MEM_TOP wrap
        instr_in = mk(2'b01, 2'b10, 8'd190, 8'd50, 6'd4);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("t2_src0", 32'(next_source), 32'd190);
        check("t2_dst0", 32'(next_destination), 32'd50);
        tick();
        check("t2_src1", 32'(next_source), 32'd191);
        check("t2_dst1", 32'(next_destination), 32'd51);
        tick();
        check("t2_src2", 32'(next_source), 32'd0);
        check("t2_dst2", 32'(next_destination), 32'd52);
        tick();
        check("t2_src3", 32'(next_source), 32'd1);
        check("t2_dst3", 32'(next_destination), 32'd53);
        tick();
        check("t2_done", 32'(done), 32'd1);
        check("t2_err", 32'(err), 32'd0);
        tick();

        // IO2 to memory with a two-cycle grant gap
        instr_in = mk(2'b00, 2'b01, 8'd230, 8'd20, 6'd3);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("t3_src0", 32'(next_source), 32'd230);
        check("t3_dst0", 32'(next_destination), 32'd20);
        tick();
        check("t3_dst1", 32'(next_destination), 32'd21);
        check("t3_rem2", 32'(remaining), 32'd2);
        grant = 1'b0;
        tick();
        check("t3_gap_bus", 32'(bus_request), 32'd1);
        check("t3_gap_instr", 32'(DMA_instruction), 32'(NOP));
        check("t3_gap_src", 32'(next_source), 32'd230);
        check("t3_gap_dst", 32'(next_destination), 32'd21);
        tick();
        check("t3_gap2_bus", 32'(bus_request), 32'd1);
        check("t3_gap2_dst", 32'(next_destination), 32'd21);
        check("t3_gap2_rem", 32'(remaining), 32'd2);
        grant = 1'b1;
        tick();
        check("t3_res_dst", 32'(next_destination), 32'd21);
        check("t3_res_instr", 32'(DMA_instruction), 32'(mk(2'b00, 2'b01, 8'd230, 8'd20, 6'd3)));
        tick();
        check("t3_dst2", 32'(next_destination), 32'd22);
        check("t3_src_hold", 32'(next_source), 32'd230);
        check("t3_not_done", 32'(done), 32'd0);
        tick();
        check("t3_done", 32'(done), 32'd1);
        tick();

        // Illegal instruction, then legal count=0
        instr_in = mk(2'b01, 2'b01, 8'd10, 8'd100, 6'd5);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("t4_ill_done", 32'(done), 32'd1);
        check("t4_ill_err", 32'(err), 32'd1);
        check("t4_ill_bus", 32'(bus_request), 32'd0);
        tick();
        check("t4_ill_idle", 32'(instr_ready), 32'd1);
        check("t4_ill_err_clr", 32'(err), 32'd0);
        instr_in = mk(2'b01, 2'b10, 8'd5, 8'd6, 6'd0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("t4_c0_done", 32'(done), 32'd1);
        check("t4_c0_err", 32'(err), 32'd0);
        check("t4_c0_bus", 32'(bus_request), 32'd0);
        tick();
        check("t4_c0_idle", 32'(instr_ready), 32'd1);

        // Deposit pointer: 64 acked cycles, one with both acks
        D_IOAck1 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check("t5_fe", 32'(firstempty), 32'(128 + i));
            check("t5_ovf_pre", 32'(ip_overflow), 32'd0);
            D_IOAck2 = (i == 10);
            tick();
        end
        check("t5_fe_wrap", 32'(firstempty), 32'd128);
        check("t5_ovf", 32'(ip_overflow), 32'd1);
        D_IOAck1 = 1'b0;
        D_IOAck2 = 1'b0;
        tick();
        check("t5_ovf_sticky", 32'(ip_overflow), 32'd1);
        check("t5_fe_hold", 32'(firstempty), 32'd128);
        D_IOAck2 = 1'b1;
        tick();
        D_IOAck2 = 1'b0;
        check("t5_ack2_only", 32'(firstempty), 32'd129);

        // Reset during XFER
        instr_in = mk(2'b01, 2'b10, 8'd0, 8'd100, 6'd8);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t6_rem5", 32'(remaining), 32'd5);
        check("t6_xfer_bus", 32'(bus_request), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_ready", 32'(instr_ready), 32'd1);
        check("t6_bus", 32'(bus_request), 32'd0);
        check("t6_instr", 32'(DMA_instruction), 32'(NOP));
        check("t6_fe", 32'(firstempty), 32'd128);
        check("t6_ovf", 32'(ip_overflow), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_rem", 32'(remaining), 32'd0);
        check("t6_src", 32'(next_source), 32'd0);
        reset = 1'b0;
        tick();
        check("t6_post_done", 32'(done), 32'd0);
        check("t6_post_ready", 32'(instr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dma_descriptor_sequencer.md
Name: dma_descriptor_sequencer

Overview:
Upstream feeder for the DMA transfer engine. It accepts one 26-bit DMA instruction at a time and requests the bus. It then drives DMA_instruction, next_source and next_destination to the engine for `count` granted cycles, advancing the memory-side address each cycle. It also maintains firstempty, the write pointer the engine uses for interrupt-driven I/O-to-memory deposits.

Parameters:
MEM_TOP, 191, highest memory address; addresses above it are I/O (IO1 192-223, IO2 224-255)
IP_BASE, 128, first address of the interrupt deposit region
IP_TOP, 191, last address of the interrupt deposit region (IP_BASE <= IP_TOP <= MEM_TOP)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
instr_in  in  26  [25:24] op, [23:22] type, [21:14] source base, [13:6] destination base, [5:0] count
instr_valid  in  1  instr_in is valid
instr_ready  out  1  sequencer can accept an instruction
grant  in  1  bus grant from arbiter (same signal the engine sees)
D_IOAck1  in  1  engine acknowledged IO1 interrupt
D_IOAck2  in  1  engine acknowledged IO2 interrupt
bus_request  out  1  request bus ownership
DMA_instruction  out  26  instruction presented to engine
next_source  out  8  current source address
next_destination  out  8  current destination address
firstempty  out  8  next free slot in deposit region
remaining  out  6  transfers still to issue
done  out  1  one-cycle pulse on instruction completion
err  out  1  one-cycle pulse, concurrent with done, on rejected instruction
ip_overflow  out  1  sticky: deposit pointer wrapped

Behaviour:
- Reset (synchronous, active-high, one clock; single clock domain):
  - state IDLE; instr_ready=1; bus_request=0; done=0; err=0; ip_overflow=0; remaining=0.
  - next_source=0; next_destination=0; firstempty=IP_BASE.
  - DMA_instruction=NOP ({2'b11,2'b00,22'b0}).
  - Reset mid-transfer abandons the instruction; no done pulse.
- DMA_instruction = latched instruction in XFER only. It is NOP in IDLE, REQ and DONE, so the engine services I/O interrupts there.
- Legal instructions:
  - op=01,type=01: memory to I/O; destination must be > MEM_TOP.
  - op=00,type=01: I/O to memory; source must be > MEM_TOP.
  - op=01,type=10: memory to memory; both addresses must be <= MEM_TOP.
  - Anything else is illegal.
- FSM IDLE / REQ / XFER / DONE:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr_in, load next_source/next_destination from the base fields, and set remaining=count.
    - Illegal instruction or count=0: go to DONE. err=1 if illegal; no bus request.
    - Otherwise go to REQ.
  - REQ: bus_request=1, instr_ready=0. grant=1 at a posedge moves to XFER. Addresses are held.
  - XFER: bus_request=1.
    - Each posedge with grant=1 counts as one issued transfer. remaining decrements, and every address <= MEM_TOP increments. MEM_TOP wraps to 0. I/O addresses hold.
    - remaining going 1->0 moves to DONE.
    - grant=0 at a posedge means no advance and return to REQ.
  - DONE: done=1 for exactly one cycle, bus_request=0, then IDLE. instr_ready=0 in DONE.
- Latency: first transfer address valid one cycle after acceptance. Minimum instruction time is count+2 cycles with grant held high.
- firstempty, independent of the FSM:
  - At a posedge with grant=1 and (D_IOAck1|D_IOAck2), firstempty increments by 1. Both acks in the same cycle still give one increment.
  - IP_TOP wraps to IP_BASE and sets ip_overflow. ip_overflow stays set until reset.
- All address arithmetic is 8-bit unsigned. remaining never underflows.

Decomposition:
- Package dma_pkg:
  - MEM_TOP, IO1/IO2 range constants.
  - op/type encodings and the NOP constant.
  - FSM state enum (IDLE, REQ, XFER, DONE).
  - Field-extract functions for instr_in.
  - Legality check function.
- Sub-module dma_ip_pointer: the firstempty counter with wrap and sticky overflow, parameterised by IP_BASE/IP_TOP.

Test Plan:
1. Reset, then memory to IO1 src=10 dst=200 count=3, grant held 1 -> src 10,11,12 on successive XFER cycles; dst stays 200; done pulses at cycle 5 after acceptance; remaining=0.
2. Memory to memory src=190 dst=50 count=4 -> src 190,191,0,1 and dst 50,51,52,53; err=0.
3. IO2 to memory src=230 dst=20 count=3, grant dropped for 2 cycles after the first transfer -> bus_request stays 1, addresses frozen at src 230 / dst 21, FSM returns to REQ; resumes dst 21,22; done after 3 granted transfers.
4. op=01 type=01 with dst=100 -> no bus_request, done=1 and err=1 in the same cycle, then IDLE; count=0 legal instruction -> done without err.
5. grant=1 with D_IOAck1 for 64 cycles, D_IOAck2 asserted together with it on one of those cycles -> firstempty 128..191, then 128; ip_overflow=1 and stays 1; one increment on the dual-ack cycle.
6. Reset asserted during XFER with remaining=5 -> next edge gives IDLE, bus_request=0, DMA_instruction=NOP, firstempty=128, no done.
